// File: rtl/alu_iterative_exec.sv
// Sequential execute unit. ADD/SUB/OR/LUI finish in one cycle. SLL/SRL use an
// iterative shifter that moves one bit per cycle. A start/busy/done handshake
// lets the control path stall while a shift is running.
module alu_iterative_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LUI = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   shift_left_q;
  logic [DATA_WIDTH-1:0]  result_q;

  logic [DATA_WIDTH-1:0]  first_result_d;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;

  assign shamt    = B_i[SHAMT_WIDTH-1:0];
  assign is_shift = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL);

  // Value written into the result register on the accept edge.
  // Shifts start from A and are then shifted in place.
  always_comb begin
    first_result_d = '0;
    case (ALU_Operation_i)
      OP_ADD:         first_result_d = A_i + B_i;
      OP_SUB:         first_result_d = A_i - B_i;
      OP_LUI:         first_result_d = B_i;
      OP_OR:          first_result_d = A_i | B_i;
      OP_SLL, OP_SRL: first_result_d = A_i;
      default:        first_result_d = '0;
    endcase
  end

  // Control FSM together with the result register and the shift counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_left_q <= 1'b0;
      result_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            result_q     <= first_result_d;
            shift_left_q <= (ALU_Operation_i == OP_SLL);
            if (is_shift && (shamt != '0)) begin
              cnt_q   <= shamt;
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= shift_left_q ? (result_q << 1) : (result_q >> 1);
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_WIDTH'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign ALU_Result_o = result_q;
  assign Zero_o       = (result_q == '0);

endmodule
